// File: rtl/quality_grader.sv
// Grades items by how many pass/fail criteria they meet.
// The grade is shown on a one-hot LED display for HOLD_CYC cycles.
// Define QUALITY_GRADER_STATS_EN to build in the per-grade saturating counters.
module quality_grader #(
  parameter int unsigned N_CRIT   = 3,
  parameter int unsigned MED_MIN  = 2,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              item_valid_i,
  input  logic [N_CRIT-1:0] crit_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              grade_valid_o,
  output logic              led_low_o,
  output logic              led_medium_o,
  output logic              led_high_o,
  output logic [1:0]        state_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  cnt_low_o,
  output logic [CNT_W-1:0]  cnt_med_o,
  output logic [CNT_W-1:0]  cnt_high_o
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StEval = 2'b01;
  localparam logic [1:0] StShow = 2'b10;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYC - 1);
  localparam logic [3:0] CntAll   = 4'(N_CRIT);
  localparam logic [3:0] CntMed   = 4'(MED_MIN);

  logic [1:0]        state_q, state_d;
  logic [N_CRIT-1:0] crit_q, crit_d;
  logic [7:0]        hold_q, hold_d;
  // LED vector is {high, medium, low}
  logic [2:0]        led_q, led_d;
  logic              gv_q, gv_d;
  logic              ovr_q, ovr_d;
  logic [3:0]        pass_cnt;
  logic [2:0]        grade_led;
  logic              busy;

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < N_CRIT; i++) begin
      pass_cnt = pass_cnt + 4'(crit_q[i]);
    end
    if (pass_cnt == CntAll) begin
      grade_led = 3'b100;
    end else if (pass_cnt >= CntMed) begin
      grade_led = 3'b010;
    end else begin
      grade_led = 3'b001;
    end
  end

  assign busy = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    hold_d  = hold_q;
    led_d   = led_q;
    gv_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (item_valid_i) begin
          crit_d  = crit_i;
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = StShow;
        led_d   = grade_led;
        gv_d    = 1'b1;
        hold_d  = HoldLast;
      end
      StShow: begin
        if (hold_q == 8'd0) begin
          state_d = StIdle;
          led_d   = 3'b000;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = 3'b000;
      end
    endcase
  end

  // Clear beats a simultaneous overrun set
  always_comb begin
    ovr_d = ovr_q;
    if (clear_i) begin
      ovr_d = 1'b0;
    end else if (item_valid_i && busy) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      crit_q  <= '0;
      hold_q  <= '0;
      led_q   <= '0;
      gv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crit_q  <= crit_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
      gv_q    <= gv_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef QUALITY_GRADER_STATS_EN
  logic [CNT_W-1:0] cnt_low_q, cnt_low_d;
  logic [CNT_W-1:0] cnt_med_q, cnt_med_d;
  logic [CNT_W-1:0] cnt_high_q, cnt_high_d;
  logic             inc;

  // Count on the EVAL->SHOW edge so the new value appears with grade_valid_o
  assign inc = (state_q == StEval);

  always_comb begin
    cnt_low_d  = cnt_low_q;
    cnt_med_d  = cnt_med_q;
    cnt_high_d = cnt_high_q;
    if (clear_i) begin
      cnt_low_d  = '0;
      cnt_med_d  = '0;
      cnt_high_d = '0;
    end else if (inc) begin
      if (grade_led[0] && (cnt_low_q != '1)) cnt_low_d = cnt_low_q + 1'b1;
      if (grade_led[1] && (cnt_med_q != '1)) cnt_med_d = cnt_med_q + 1'b1;
      if (grade_led[2] && (cnt_high_q != '1)) cnt_high_d = cnt_high_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_low_q  <= '0;
      cnt_med_q  <= '0;
      cnt_high_q <= '0;
    end else begin
      cnt_low_q  <= cnt_low_d;
      cnt_med_q  <= cnt_med_d;
      cnt_high_q <= cnt_high_d;
    end
  end

  assign cnt_low_o  = cnt_low_q;
  assign cnt_med_o  = cnt_med_q;
  assign cnt_high_o = cnt_high_q;
`else
  assign cnt_low_o  = '0;
  assign cnt_med_o  = '0;
  assign cnt_high_o = '0;
`endif

  assign busy_o        = busy;
  assign grade_valid_o = gv_q;
  assign led_low_o     = led_q[0];
  assign led_medium_o  = led_q[1];
  assign led_high_o    = led_q[2];
  assign state_o       = state_q;
  assign overrun_o     = ovr_q;

endmodule
